// File: rtl/noise_ctrl_pkg.sv
// Shared constants for the channel-4 noise controller: divisor table, frame-sequencer
// step masks, register field positions and the period helper.
package noise_ctrl_pkg;

  localparam int TIMER_W = 20;

  localparam logic [6:0] DIV_TABLE [0:7] = '{7'd8, 7'd16, 7'd32, 7'd48,
                                             7'd64, 7'd80, 7'd96, 7'd112};

  localparam logic [7:0] FS_LEN_STEPS = 8'b0101_0101;
  localparam logic [2:0] FS_ENV_STEP  = 3'd7;
  localparam logic [6:0] LEN_MAX      = 7'd64;
  localparam logic [3:0] S_FREEZE     = 4'd14;

  localparam int NR42_DIR_BIT    = 3;
  localparam int NR43_WIDTH_BIT  = 3;
  localparam int NR44_TRIG_BIT   = 7;
  localparam int NR44_LEN_EN_BIT = 6;

  // Shift-clock period in APU ticks; wraps to TIMER_W bits for the frozen shifts.
  function automatic logic [TIMER_W-1:0] noise_period(input logic [2:0] r,
                                                     input logic [3:0] s);
    logic [TIMER_W-1:0] div;
    div = {{(TIMER_W-7){1'b0}}, DIV_TABLE[r]};
    return div << s;
  endfunction

endpackage

// File: rtl/noise_channel_ctrl_frame_sequencer.sv
// 512 Hz frame sequencer: APU-tick prescaler plus 3-bit step counter, emitting
// one-cycle length and envelope clock strobes.
module frame_sequencer
  import noise_ctrl_pkg::*;
#(
  parameter int FS_DIV = 8192
) (
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic I_APU_TICK,
  output logic O_LEN_CLK,
  output logic O_ENV_CLK
);

  localparam int PW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(FS_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [2:0]    step_q;

  // Strobes belong to the step being left, so step 0 produces the first length clock.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      presc_q   <= PRESC_RELOAD;
      step_q    <= 3'd0;
      O_LEN_CLK <= 1'b0;
      O_ENV_CLK <= 1'b0;
    end else begin
      O_LEN_CLK <= 1'b0;
      O_ENV_CLK <= 1'b0;
      if (I_APU_TICK) begin
        if (presc_q == '0) begin
          presc_q   <= PRESC_RELOAD;
          step_q    <= step_q + 3'd1;
          O_LEN_CLK <= FS_LEN_STEPS[step_q];
          O_ENV_CLK <= (step_q == FS_ENV_STEP);
        end else begin
          presc_q <= presc_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/noise_channel_ctrl.sv
// Channel-4 noise controller: NR41-NR44 decode, length counter, volume envelope and
// the LFSR shift-clock timer driving the randwave generator.
module noise_channel_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int FS_DIV = 8192
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_APU_TICK,
  input  logic       I_NR41_WR,
  input  logic       I_NR42_WR,
  input  logic       I_NR43_WR,
  input  logic       I_NR44_WR,
  input  logic [7:0] I_WDATA,
  output logic       O_SHIFT_TICK,
  output logic       O_LFSR_RESET,
  output logic       O_BIT_WIDTH,
  output logic [3:0] O_VOLUME,
  output logic       O_WAVEFORM_EN
);

  logic [7:0]         nr42_q;
  logic [7:0]         nr43_q;
  logic               len_en_q;
  logic [6:0]         len_q;
  logic [2:0]         env_cnt_q;
  logic [TIMER_W-1:0] timer_q;

  logic               len_clk;
  logic               env_clk;
  logic               trigger;
  logic               dac_on;
  logic               len_dec;
  logic               env_step;
  logic               timer_frozen;
  logic [TIMER_W-1:0] period;

  frame_sequencer #(.FS_DIV(FS_DIV)) u_fs (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .I_APU_TICK (I_APU_TICK),
    .O_LEN_CLK  (len_clk),
    .O_ENV_CLK  (env_clk)
  );

  assign trigger      = I_NR44_WR & I_WDATA[NR44_TRIG_BIT];
  assign dac_on       = |nr42_q[7:3];
  assign timer_frozen = (nr43_q[7:4] >= S_FREEZE);
  assign period       = noise_period(nr43_q[2:0], nr43_q[7:4]);

  // A trigger swallows coincident sequencer clocks; an NR41 load swallows the decrement.
  assign len_dec  = len_clk & ~trigger & ~I_NR41_WR & len_en_q & (len_q != 7'd0);
  assign env_step = env_clk & ~trigger & O_WAVEFORM_EN & (nr42_q[2:0] != 3'd0);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      nr42_q        <= 8'd0;
      nr43_q        <= 8'd0;
      len_en_q      <= 1'b0;
      len_q         <= 7'd0;
      env_cnt_q     <= 3'd0;
      timer_q       <= '0;
      O_SHIFT_TICK  <= 1'b0;
      O_LFSR_RESET  <= 1'b0;
      O_BIT_WIDTH   <= 1'b0;
      O_VOLUME      <= 4'd0;
      O_WAVEFORM_EN <= 1'b0;
    end else begin
      O_SHIFT_TICK <= 1'b0;
      O_LFSR_RESET <= trigger;

      if (I_NR42_WR) nr42_q <= I_WDATA;
      if (I_NR43_WR) begin
        nr43_q      <= I_WDATA;
        O_BIT_WIDTH <= I_WDATA[NR43_WIDTH_BIT];
      end
      if (I_NR44_WR) len_en_q <= I_WDATA[NR44_LEN_EN_BIT];

      if (I_NR41_WR) begin
        len_q <= LEN_MAX - {1'b0, I_WDATA[5:0]};
      end else if (trigger) begin
        if (len_q == 7'd0) len_q <= LEN_MAX;
      end else if (len_dec) begin
        len_q <= len_q - 7'd1;
      end

      if (trigger) begin
        O_WAVEFORM_EN <= dac_on;
      end else if (I_NR42_WR && (I_WDATA[7:3] == 5'd0)) begin
        O_WAVEFORM_EN <= 1'b0;
      end else if (len_dec && (len_q == 7'd1)) begin
        O_WAVEFORM_EN <= 1'b0;
      end

      // Period changes from NR43 land only when the count next reaches 1.
      if (trigger) begin
        timer_q <= period;
      end else if (I_APU_TICK && !timer_frozen) begin
        if (timer_q <= TIMER_W'(1)) begin
          timer_q      <= period;
          O_SHIFT_TICK <= O_WAVEFORM_EN;
        end else begin
          timer_q <= timer_q - 1'b1;
        end
      end

      if (trigger) begin
        O_VOLUME  <= nr42_q[7:4];
        env_cnt_q <= nr42_q[2:0];
      end else if (env_step) begin
        if (env_cnt_q <= 3'd1) begin
          env_cnt_q <= nr42_q[2:0];
          if (nr42_q[NR42_DIR_BIT]) begin
            if (O_VOLUME != 4'd15) O_VOLUME <= O_VOLUME + 4'd1;
          end else begin
            if (O_VOLUME != 4'd0) O_VOLUME <= O_VOLUME - 4'd1;
          end
        end else begin
          env_cnt_q <= env_cnt_q - 3'd1;
        end
      end
    end
  end

endmodule
